dm_access_unit: RTL and testbench

- CPU-side initiator of the data-memory bus: the M-stage load/store unit of the pipelined MIPS core.
- Accepts one memory op per cycle from the E/M boundary and holds it in an internal M register.
- Drives m_data_addr, m_data_wdata, m_data_byteen and m_inst_addr from that register, samples m_data_rdata, and delivers aligned, extended load data in a registered W-stage result.

---
 rtl/dm_pkg.sv | 41 ++++
 rtl/dm_lane_ext.sv | 45 ++++
 rtl/dm_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_dm_access_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared op encodings, exception codes and widths for the
//            data-memory access unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 4;
    localparam int REG_W = 5;
    localparam int EXC_W = 5;
    localparam int BE_W  = 4;

    localparam logic [OP_W-1:0] OP_NONE = 4'd0;
    localparam logic [OP_W-1:0] OP_LW   = 4'd1;
    localparam logic [OP_W-1:0] OP_LH   = 4'd2;
    localparam logic [OP_W-1:0] OP_LHU  = 4'd3;
    localparam logic [OP_W-1:0] OP_LB   = 4'd4;
    localparam logic [OP_W-1:0] OP_LBU  = 4'd5;
    localparam logic [OP_W-1:0] OP_SW   = 4'd6;
    localparam logic [OP_W-1:0] OP_SH   = 4'd7;
    localparam logic [OP_W-1:0] OP_SB   = 4'd8;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

    function automatic logic op_is_load(input logic [OP_W-1:0] op);
        return (op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU});
    endfunction

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return (op inside {OP_SW, OP_SH, OP_SB});
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_lane_ext.sv
// ============================================================================
// Module   : dm_lane_ext
// Purpose  : Selects the addressed byte/half lane of a read word and applies
//            sign or zero extension; non-load ops yield zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        unique case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    always_comb begin
        data = '0;
        case (op)
            OP_LW:   data = rdata;
            OP_LH:   data = {{16{w_half[15]}}, w_half};
            OP_LHU:  data = {16'h0000, w_half};
            OP_LB:   data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  data = {24'h000000, w_byte};
            default: data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_access_unit.sv
// ============================================================================
// Module   : dm_access_unit
// Purpose  : M-stage load/store unit: registers the E/M op, drives the data
//            bus and produces the registered, extended W-stage load result.
//            Define DM_ADDR_EXC_EN for misalignment/range exceptions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_access_unit
    import dm_pkg::*;
#(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter int unsigned DM_BYTES = 16384,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [OP_W-1:0]   req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN-1:0]   req_pc,
    input  logic [REG_W-1:0]  req_rd,
    input  logic              stall,
    input  logic              flush,
    output logic [XLEN-1:0]   m_data_addr,
    output logic [XLEN-1:0]   m_data_wdata,
    output logic [BE_W-1:0]   m_data_byteen,
    input  logic [XLEN-1:0]   m_data_rdata,
    output logic [XLEN-1:0]   m_inst_addr,
    output logic              w_valid,
    output logic              w_is_load,
    output logic [REG_W-1:0]  w_rd,
    output logic [XLEN-1:0]   w_data,
    output logic [XLEN-1:0]   w_pc,
    output logic [EXC_W-1:0]  w_exc
);

`ifdef DM_ADDR_EXC_EN
    localparam bit ADDR_EXC_EN = 1'b1;
`else
    localparam bit ADDR_EXC_EN = 1'b0;
`endif

    logic              m_valid_q, m_valid_d;
    logic [OP_W-1:0]   m_op_q,    m_op_d;
    logic [XLEN-1:0]   m_addr_q,  m_addr_d;
    logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
    logic [XLEN-1:0]   m_pc_q,    m_pc_d;
    logic [REG_W-1:0]  m_rd_q,    m_rd_d;

    logic              w_valid_q,   w_valid_d;
    logic              w_is_load_q, w_is_load_d;
    logic [REG_W-1:0]  w_rd_q,      w_rd_d;
    logic [XLEN-1:0]   w_data_q,    w_data_d;
    logic [XLEN-1:0]   w_pc_q,      w_pc_d;
    logic [EXC_W-1:0]  w_exc_q,     w_exc_d;

    logic              w_m_ld, w_m_st, w_misalign, w_out_range;
    logic [32:0]       w_off;
    logic [EXC_W-1:0]  w_m_exc;
    logic [BE_W-1:0]   w_be_raw;
    logic [XLEN-1:0]   w_lane_data;

    always_comb begin
        m_valid_d = m_valid_q;
        m_op_d    = m_op_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_pc_d    = m_pc_q;
        m_rd_d    = m_rd_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (!stall) begin
            m_valid_d = req_valid && (op_is_load(req_op) || op_is_store(req_op));
            m_op_d    = req_op;
            m_addr_d  = req_addr;
            m_wdata_d = req_wdata;
            m_pc_d    = req_pc;
            m_rd_d    = req_rd;
        end
    end

    // Range check in 33 bits so addresses below DM_BASE or past a wrapped
    // DM_BASE+DM_BYTES are both caught without an overflowing add.
    always_comb begin
        w_m_ld      = op_is_load(m_op_q);
        w_m_st      = op_is_store(m_op_q);
        w_off       = {1'b0, m_addr_q} - {1'b0, DM_BASE};
        w_out_range = (w_off >= 33'(DM_BYTES));
        case (m_op_q)
            OP_LW, OP_SW:          w_misalign = |m_addr_q[1:0];
            OP_LH, OP_LHU, OP_SH:  w_misalign = m_addr_q[0];
            default:               w_misalign = 1'b0;
        endcase
        w_m_exc = EXC_NONE;
        if (ADDR_EXC_EN && m_valid_q && (w_misalign || w_out_range)) begin
            if (w_m_ld)      w_m_exc = EXC_ADEL;
            else if (w_m_st) w_m_exc = EXC_ADES;
        end
    end

    always_comb begin
        w_be_raw     = '0;
        m_data_wdata = m_wdata_q;
        case (m_op_q)
            OP_SW: w_be_raw = 4'b1111;
            OP_SH: begin
                w_be_raw     = 4'b0011 << {m_addr_q[1], 1'b0};
                m_data_wdata = {2{m_wdata_q[15:0]}};
            end
            OP_SB: begin
                w_be_raw     = 4'b0001 << m_addr_q[1:0];
                m_data_wdata = {4{m_wdata_q[7:0]}};
            end
            default: w_be_raw = '0;
        endcase
        m_data_byteen = (m_valid_q && w_m_st && (w_m_exc == EXC_NONE) && !stall && !flush)
                        ? w_be_raw : '0;
    end

    assign m_data_addr = {m_addr_q[31:2], 2'b00};
    assign m_inst_addr = m_pc_q;

    dm_lane_ext u_lane_ext (
        .op      (m_op_q),
        .addr_lo (m_addr_q[1:0]),
        .rdata   (m_data_rdata),
        .data    (w_lane_data)
    );

    always_comb begin
        w_valid_d   = w_valid_q;
        w_is_load_d = w_is_load_q;
        w_rd_d      = w_rd_q;
        w_data_d    = w_data_q;
        w_pc_d      = w_pc_q;
        w_exc_d     = w_exc_q;
        if (stall || flush) begin
            w_valid_d = 1'b0;
        end else begin
            w_valid_d   = m_valid_q;
            w_is_load_d = m_valid_q && w_m_ld;
            w_rd_d      = m_rd_q;
            w_pc_d      = m_pc_q;
            w_exc_d     = w_m_exc;
            w_data_d    = (w_m_ld && (w_m_exc == EXC_NONE)) ? w_lane_data : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q   <= 1'b0;
            m_op_q      <= OP_NONE;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_pc_q      <= PC_RESET;
            m_rd_q      <= '0;
            w_valid_q   <= 1'b0;
            w_is_load_q <= 1'b0;
            w_rd_q      <= '0;
            w_data_q    <= '0;
            w_pc_q      <= PC_RESET;
            w_exc_q     <= EXC_NONE;
        end else begin
            m_valid_q   <= m_valid_d;
            m_op_q      <= m_op_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_pc_q      <= m_pc_d;
            m_rd_q      <= m_rd_d;
            w_valid_q   <= w_valid_d;
            w_is_load_q <= w_is_load_d;
            w_rd_q      <= w_rd_d;
            w_data_q    <= w_data_d;
            w_pc_q      <= w_pc_d;
            w_exc_q     <= w_exc_d;
        end
    end

    assign w_valid   = w_valid_q;
    assign w_is_load = w_is_load_q;
    assign w_rd      = w_rd_q;
    assign w_data    = w_data_q;
    assign w_pc      = w_pc_q;
    assign w_exc     = w_exc_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_unit.sv
// ============================================================================
// Module   : tb_dm_access_unit
// Purpose  : Scoreboard bench for dm_access_unit with a small byte-lane
//            data-memory model on the bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_access_unit;
    import dm_pkg::*;

    localparam int unsigned DM_BYTES = 16384;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        ld;
    } wres_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic [4:0]  req_rd;
    logic        stall, flush;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata, m_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_valid, w_is_load;
    logic [4:0]  w_rd, w_exc;
    logic [31:0] w_data, w_pc;

    logic [31:0] mem [0:4095];
    bus_t        bus_q[$];
    wres_t       w_q[$];
    int          checks = 0;
    int          errors = 0;

    dm_access_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_pc        (req_pc),
        .req_rd        (req_rd),
        .stall         (stall),
        .flush         (flush),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .m_inst_addr   (m_inst_addr),
        .w_valid       (w_valid),
        .w_is_load     (w_is_load),
        .w_rd          (w_rd),
        .w_data        (w_data),
        .w_pc          (w_pc),
        .w_exc         (w_exc)
    );

    always #5 clk = ~clk;

    assign m_data_rdata = (m_data_addr < DM_BYTES) ? mem[m_data_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (m_data_addr < DM_BYTES) begin
            for (int i = 0; i < 4; i++)
                if (m_data_byteen[i]) mem[m_data_addr[13:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse and every W result must match the next
    // queued expectation, in order.
    always @(negedge clk) begin
        bus_t  b;
        wres_t w;
        if (m_data_byteen != 4'b0000) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_write_be", {28'h0, m_data_byteen}, 32'h0);
            end else begin
                b = bus_q.pop_front();
                chk("bus_addr",  m_data_addr,  b.addr);
                chk("bus_wdata", m_data_wdata, b.wdata);
                chk("bus_be",    {28'h0, m_data_byteen}, {28'h0, b.be});
                chk("bus_pc",    m_inst_addr,  b.pc);
            end
        end
        if (w_valid === 1'b1) begin
            if (w_q.size() == 0) begin
                chk("unexpected_w_pc", w_pc, 32'h0);
            end else begin
                w = w_q.pop_front();
                chk("w_rd",      {27'h0, w_rd},  {27'h0, w.rd});
                chk("w_data",    w_data,         w.data);
                chk("w_pc",      w_pc,           w.pc);
                chk("w_exc",     {27'h0, w_exc}, {27'h0, w.exc});
                chk("w_is_load", {31'h0, w_is_load}, {31'h0, w.ld});
            end
        end
    end

    task automatic push_bus(input logic [31:0] a, wd, input logic [3:0] be, input logic [31:0] pc);
        bus_t b;
        b.addr = a; b.wdata = wd; b.be = be; b.pc = pc;
        bus_q.push_back(b);
    endtask

    task automatic push_w(input logic [4:0] rd, input logic [31:0] d, pc, input logic [4:0] exc,
                          input logic ld);
        wres_t w;
        w.rd = rd; w.data = d; w.pc = pc; w.exc = exc; w.ld = ld;
        w_q.push_back(w);
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, wd, pc, input logic [4:0] rd);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = OP_NONE;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0] = 32'hCAFE_F00D;
        reset = 1'b1; req_valid = 1'b0; req_op = OP_NONE; req_addr = '0; req_wdata = '0;
        req_pc = '0; req_rd = '0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_valid", {31'h0, w_valid}, 32'h0);
        chk("rst_byteen",  {28'h0, m_data_byteen}, 32'h0);
        chk("rst_w_pc",    w_pc, 32'h0000_3000);
        chk("rst_inst",    m_inst_addr, 32'h0000_3000);
        chk("rst_w_exc",   {27'h0, w_exc}, 32'h0);
        chk("rst_w_data",  w_data, 32'h0);
        reset = 1'b0;
        idle(1);

        push_bus(32'h10, 32'h1234_5678, 4'b1111, 32'h100); push_w(0, 0, 32'h100, EXC_NONE, 0);
        send(OP_SW, 32'h10, 32'h1234_5678, 32'h100, 0);
        push_bus(32'h10, 32'hABAB_ABAB, 4'b1000, 32'h104); push_w(0, 0, 32'h104, EXC_NONE, 0);
        send(OP_SB, 32'h13, 32'h0000_00AB, 32'h104, 0);
        idle(1);
        push_w(3, 32'hFFFF_FFAB, 32'h108, EXC_NONE, 1);
        send(OP_LB, 32'h13, 0, 32'h108, 3);
        push_w(4, 32'h0000_00AB, 32'h10C, EXC_NONE, 1);
        send(OP_LBU, 32'h13, 0, 32'h10C, 4);

        push_bus(32'h20, 32'h8001_8001, 4'b1100, 32'h110); push_w(0, 0, 32'h110, EXC_NONE, 0);
        send(OP_SH, 32'h22, 32'h0000_8001, 32'h110, 0);
        idle(1);
        push_w(5, 32'hFFFF_8001, 32'h114, EXC_NONE, 1);
        send(OP_LH, 32'h22, 0, 32'h114, 5);
        push_w(6, 32'h0000_8001, 32'h118, EXC_NONE, 1);
        send(OP_LHU, 32'h22, 0, 32'h118, 6);
        push_w(2, 32'hAB34_5678, 32'h11C, EXC_NONE, 1);
        send(OP_LW, 32'h10, 0, 32'h11C, 2);
        push_w(10, 32'h0000_0078, 32'h120, EXC_NONE, 1);
        send(OP_LBU, 32'h10, 0, 32'h120, 10);
        push_w(11, 32'h0000_0056, 32'h124, EXC_NONE, 1);
        send(OP_LB, 32'h11, 0, 32'h124, 11);
        send(4'hF, 32'h10, 0, 32'h128, 12);

`ifdef DM_ADDR_EXC_EN
        push_w(8, 32'h0, 32'h130, EXC_ADEL, 1);
`else
        push_w(8, 32'hCAFE_F00D, 32'h130, EXC_NONE, 1);
`endif
        send(OP_LW, 32'h2, 0, 32'h130, 8);
        chk("lw_mis_addr", m_data_addr, 32'h0);
        chk("lw_mis_be",   {28'h0, m_data_byteen}, 32'h0);
`ifdef DM_ADDR_EXC_EN
        push_w(0, 32'h0, 32'h134, EXC_ADES, 0);
        send(OP_SH, 32'h4001, 32'h1234, 32'h134, 0);
        chk("sh_oor_be", {28'h0, m_data_byteen}, 32'h0);
`else
        push_bus(32'h4000, 32'h1234_1234, 4'b0011, 32'h134); push_w(0, 0, 32'h134, EXC_NONE, 0);
        send(OP_SH, 32'h4001, 32'h1234, 32'h134, 0);
`endif
        idle(1);

        // Stalled store: no write while held, one pulse on release.
        push_bus(32'h30, 32'h5555_5555, 4'b0011, 32'h140); push_w(0, 0, 32'h140, EXC_NONE, 0);
        send(OP_SH, 32'h30, 32'h0000_5555, 32'h140, 0);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1 chk("stall_be", {28'h0, m_data_byteen}, 32'h0);
            @(posedge clk); #1;
            chk("stall_w_valid", {31'h0, w_valid}, 32'h0);
        end
        stall = 1'b0;
        idle(2);
        chk("stall_mem", mem[12], 32'h0000_5555);

        send(OP_LW, 32'h10, 0, 32'h150, 7);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_w_valid", {31'h0, w_valid}, 32'h0);

        send(OP_LB, 32'h13, 0, 32'h160, 9);
        stall = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        stall = 1'b0; flush = 1'b0;
        chk("sf_w_valid0", {31'h0, w_valid}, 32'h0);
        idle(1);
        chk("sf_w_valid1", {31'h0, w_valid}, 32'h0);

        send(OP_SW, 32'h40, 32'hDEAD_BEEF, 32'h200, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_be",      {28'h0, m_data_byteen}, 32'h0);
        chk("arst_w_valid", {31'h0, w_valid}, 32'h0);
        chk("arst_w_pc",    w_pc, 32'h0000_3000);
        chk("arst_inst",    m_inst_addr, 32'h0000_3000);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("arst_mem", mem[16], 32'h0);
        idle(3);

        chk("bus_q_empty", bus_q.size(), 32'h0);
        chk("w_q_empty",   w_q.size(),   32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
